ram_bist_ctrl: RTL and testbench

- Self-test sequencer sitting directly upstream of the 64x32 single-port block RAM (clka/wea/addra/dina/douta).
- On a debounced Start button press it fills every word with a switch-selected pattern, reads all words back, and compares each word.
- Reports PASS or FAIL, with the first failing address, on the 8 board LEDs.
- Replaces manual per-address writes from switches with an automatic full-array test.

---
 rtl/ram_bist_ctrl_pkg.sv | 35 +++
 rtl/ram_bist_ctrl_if.sv | 13 +
 rtl/ram_bist_ctrl_btn_debounce.sv | 41 ++++
 rtl/ram_bist_ctrl.sv | 133 +++++++++++++
 tb/tb_ram_bist_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_bist_ctrl_pkg.sv
// Shared constants and helpers for the RAM self-test sequencer.
// Holds the state codes, base patterns, LED status prefixes and the word-pattern function.
package ram_bist_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FILL  = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] PASS  = 3'd4;
  localparam logic [2:0] FAIL  = 3'd5;

  localparam logic [31:0] PAT_SW0 = 32'h0000_0001;
  localparam logic [31:0] PAT_SW1 = 32'hFFFF_FFFF;
  localparam logic [31:0] PAT_SW2 = 32'h0001_0000;
  localparam logic [31:0] PAT_SW3 = 32'h5555_5555;

  localparam logic [1:0] LED_BUSY = 2'b10;
  localparam logic [1:0] LED_PASS = 2'b01;
  localparam logic [1:0] LED_FAIL = 2'b11;

  function automatic logic [31:0] base_sel(input logic [1:0] sw);
    case (sw)
      2'b00:   return PAT_SW0;
      2'b01:   return PAT_SW1;
      2'b10:   return PAT_SW2;
      default: return PAT_SW3;
    endcase
  endfunction

  // Folding the address into the data makes address aliasing show up as a data mismatch.
  function automatic logic [31:0] pattern(input logic [31:0] base, input logic [31:0] addr);
    return base ^ addr;
  endfunction

endpackage

// File: rtl/ram_bist_ctrl_if.sv
// Single-port block RAM connection between the self-test sequencer and the RAM.
interface ram_bist_ctrl_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic              Ram_we;
  logic [ADDR_W-1:0] Ram_addr;
  logic [DATA_W-1:0] Ram_din;
  logic [DATA_W-1:0] Ram_dout;

  modport master (output Ram_we, output Ram_addr, output Ram_din, input Ram_dout);
  modport slave  (input Ram_we, input Ram_addr, input Ram_din, output Ram_dout);
endinterface

// File: rtl/ram_bist_ctrl_btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer, stability counter and rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Btn_raw,
  output logic Pulse
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_prev_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= Btn_raw;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      // Counter tracks consecutive samples that disagree with the accepted level.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign Pulse = level_q & ~level_prev_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM self-test sequencer: fills every word with an address-folded pattern, reads it back
// through a latency-matched delay line and reports the first failing address.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W          = 6,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned RD_LAT          = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [1:0]        SW,
  ram_bist_ctrl_if.master   ram,
  output logic              Busy,
  output logic              Done,
  output logic              Fail,
  output logic [ADDR_W-1:0] Err_addr,
  output logic [7:0]        LED
);
  logic              start_pulse;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [31:0]       base_q, base_d;
  logic [ADDR_W-1:0] dly_addr_q [RD_LAT];
  logic [RD_LAT-1:0] dly_vld_q;
  logic [ADDR_W-1:0] ram_addr, cmp_addr;
  logic              cmp_vld, mismatch;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .Clk     (Clk),
    .Rst     (Rst),
    .Btn_raw (Start),
    .Pulse   (start_pulse)
  );

  assign cmp_addr = dly_addr_q[RD_LAT-1];
  assign cmp_vld  = dly_vld_q[RD_LAT-1] && (state_q == READ || state_q == DRAIN);
  assign mismatch = cmp_vld && (ram.Ram_dout != DATA_W'(pattern(base_q, 32'(cmp_addr))));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE, PASS, FAIL: begin
        if (start_pulse) begin
          state_d    = FILL;
          cnt_d      = '0;
          base_d     = base_sel(SW);
          err_addr_d = '0;
        end
      end
      FILL: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) state_d = READ;
      end
      READ: begin
        if (mismatch) begin
          state_d    = FAIL;
          err_addr_d = cmp_addr;
        end else begin
          // Wraps to zero on the last address, which also starts the drain count.
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == '1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mismatch) begin
          state_d    = FAIL;
          err_addr_d = cmp_addr;
        end else if (cnt_q == ADDR_W'(RD_LAT - 1)) begin
          state_d = PASS;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      err_addr_q  <= '0;
      addr_hold_q <= '0;
      dly_vld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) dly_addr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      err_addr_q  <= err_addr_d;
      addr_hold_q <= ram_addr;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        dly_vld_q[i]  <= dly_vld_q[i-1];
        dly_addr_q[i] <= dly_addr_q[i-1];
      end
      dly_vld_q[0]  <= (state_q == READ);
      dly_addr_q[0] <= cnt_q;
      // First mismatch ends the run; reads still in flight are dropped.
      if (mismatch) dly_vld_q <= '0;
    end
  end

  assign ram_addr     = (state_q == FILL || state_q == READ) ? cnt_q : addr_hold_q;
  assign ram.Ram_addr = ram_addr;
  assign ram.Ram_we   = (state_q == FILL);
  assign ram.Ram_din  = (state_q == FILL) ? DATA_W'(pattern(base_q, 32'(cnt_q))) : '0;

  assign Busy     = (state_q == FILL) || (state_q == READ) || (state_q == DRAIN);
  assign Done     = (state_q == PASS) || (state_q == FAIL);
  assign Fail     = (state_q == FAIL);
  assign Err_addr = err_addr_q;

  always_comb begin
    case (state_q)
      FILL, READ, DRAIN: LED = {LED_BUSY, 6'(ram_addr)};
      PASS:              LED = {LED_PASS, 6'b0};
      FAIL:              LED = {LED_FAIL, 6'(err_addr_q)};
      default:           LED = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: two instances (read latency 1 and 3) on shared stimulus, each with
// its own RAM model, checked every cycle against a run-timeline model plus literal expectations.
module tb_ram_bist_ctrl;
  logic       Clk = 1'b0;
  logic       Rst, Start, flip_on;
  logic [1:0] SW;
  int         cyc = 0;
  int         n_chk = 0, n_err = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  ram_bist_ctrl_if #(.ADDR_W(6), .DATA_W(32)) bus1 ();
  ram_bist_ctrl_if #(.ADDR_W(6), .DATA_W(32)) bus3 ();

  logic       busy1, done1, fail1, busy3, done3, fail3;
  logic [5:0] err1, err3;
  logic [7:0] led1, led3;

  ram_bist_ctrl #(.ADDR_W(6), .DATA_W(32), .RD_LAT(1), .DEBOUNCE_CYCLES(4)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .SW(SW), .ram(bus1),
    .Busy(busy1), .Done(done1), .Fail(fail1), .Err_addr(err1), .LED(led1)
  );
  ram_bist_ctrl #(.ADDR_W(6), .DATA_W(32), .RD_LAT(3), .DEBOUNCE_CYCLES(4)) u_dut3 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .SW(SW), .ram(bus3),
    .Busy(busy3), .Done(done3), .Fail(fail3), .Err_addr(err3), .LED(led3)
  );

  // RAM models: address registered RD_LAT times before data appears; optional bit-0 fault at 0x2A.
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [5:0]  rp1, rp3a, rp3b, rp3c;
  always @(posedge Clk) begin
    if (bus1.Ram_we) mem1[bus1.Ram_addr] <= bus1.Ram_din;
    if (bus3.Ram_we) mem3[bus3.Ram_addr] <= bus3.Ram_din;
    rp1  <= bus1.Ram_addr;
    rp3a <= bus3.Ram_addr;
    rp3b <= rp3a;
    rp3c <= rp3b;
  end
  assign bus1.Ram_dout = mem1[rp1] ^ {31'b0, flip_on && rp1 == 6'h2A};
  assign bus3.Ram_dout = mem3[rp3c] ^ {31'b0, flip_on && rp3c == 6'h2A};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] base_of(input logic [1:0] sw);
    case (sw)
      2'b00:   return 32'h0000_0001;
      2'b01:   return 32'hFFFF_FFFF;
      2'b10:   return 32'h0001_0000;
      default: return 32'h5555_5555;
    endcase
  endfunction

  // Model: phase 0 idle, 1 running (k = cycles since start pulse), 2 pass, 3 fail.
  localparam int LAT [2] = '{1, 3};
  int          m_phase [2], m_k [2], m_failk [2];
  logic [31:0] m_base [2];
  logic [5:0]  m_err [2], m_addr [2];
  logic        h [6];
  logic        lvl, m_pulse, m_valid = 1'b0;

  task automatic cmp_dut(input int i, input logic we, input logic [5:0] addr,
                         input logic [31:0] din, input logic busy, input logic done,
                         input logic fail, input logic [5:0] err, input logic [7:0] led);
    logic        e_we;
    logic [31:0] e_din;
    logic [7:0]  e_led;
    e_we  = (m_phase[i] == 1) && (m_k[i] <= 64);
    e_din = e_we ? (m_base[i] ^ {26'b0, m_addr[i]}) : 32'h0;
    case (m_phase[i])
      1:       e_led = {2'b10, m_addr[i]};
      2:       e_led = 8'h40;
      3:       e_led = {2'b11, m_err[i]};
      default: e_led = 8'h00;
    endcase
    check($sformatf("cycle %0d lat%0d {we,addr,din,busy,done,fail,err,led}", cyc, LAT[i]),
          {8'b0, we, addr, din, busy, done, fail, err, led},
          {8'b0, e_we, m_addr[i], e_din, m_phase[i] == 1, m_phase[i] >= 2, m_phase[i] == 3,
           m_err[i], e_led});
  endtask

  always @(negedge Clk) begin
    if (m_valid) begin
      cmp_dut(0, bus1.Ram_we, bus1.Ram_addr, bus1.Ram_din, busy1, done1, fail1, err1, led1);
      cmp_dut(1, bus3.Ram_we, bus3.Ram_addr, bus3.Ram_din, busy3, done3, fail3, err3, led3);
    end
    if (Rst) begin
      m_valid = 1'b1;
      lvl     = 1'b0;
      m_pulse = 1'b0;
      for (int j = 0; j < 6; j++) h[j] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = 0; m_k[i] = 0; m_failk[i] = -1;
        m_base[i] = '0; m_err[i] = '0; m_addr[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_phase[i] == 1) begin
          m_k[i]++;
          if (m_k[i] == m_failk[i]) begin
            m_phase[i] = 3;
            m_err[i]   = 6'h2A;
          end else if (m_k[i] == 129 + LAT[i]) begin
            m_phase[i] = 2;
          end
        end else if (m_pulse) begin
          m_phase[i] = 1;
          m_k[i]     = 1;
          m_base[i]  = base_of(SW);
          m_err[i]   = '0;
          m_failk[i] = flip_on ? 66 + 42 + LAT[i] : -1;
        end
        if (m_phase[i] == 1 && m_k[i] <= 64)       m_addr[i] = 6'(m_k[i] - 1);
        else if (m_phase[i] == 1 && m_k[i] <= 128) m_addr[i] = 6'(m_k[i] - 65);
      end
      // Debounced level follows Start seen two cycles late, after four agreeing samples.
      for (int j = 5; j > 0; j--) h[j] = h[j-1];
      h[0] = Start;
      if (h[2] != lvl && h[3] != lvl && h[4] != lvl && h[5] != lvl) begin
        lvl     = ~lvl;
        m_pulse = lvl;
      end else begin
        m_pulse = 1'b0;
      end
    end
  end

  logic [31:0] din63 = '0, din0 = '0;
  int          runs = 0;
  logic        busy1_d = 1'b0;
  always @(negedge Clk) begin
    if (bus1.Ram_we && bus1.Ram_addr == 6'd63) din63 = bus1.Ram_din;
    if (bus1.Ram_we && bus1.Ram_addr == 6'd0)  din0  = bus1.Ram_din;
    if (busy1 && !busy1_d) runs++;
    busy1_d = busy1;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input int n);
    Start = 1'b1;
    repeat (n) step();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int p, output int t1, output int t3);
    bit sb1, sb3;
    sb1 = 0; sb3 = 0; t1 = -1; t3 = -1;
    for (int i = 0; i < 400 && (t1 < 0 || t3 < 0); i++) begin
      step();
      if (busy1) sb1 = 1;
      if (busy3) sb3 = 1;
      if (done1 && sb1 && t1 < 0) t1 = cyc - p;
      if (done3 && sb3 && t3 < 0) t3 = cyc - p;
    end
  endtask

  int  p, t1, t3;
  bit  found;

  initial begin
    Rst = 1'b1; Start = 1'b0; SW = 2'b00; flip_on = 1'b0;
    repeat (5) step();
    Rst = 1'b0;
    repeat (100) step();
    check("idle_led", led1, 8'h00);
    check("idle_busy", busy1, 1'b0);
    check("idle_done", done1, 1'b0);
    check("idle_we", bus1.Ram_we, 1'b0);

    // Bouncy presses no longer than three cycles.
    press(2); repeat (2) step();
    press(3); repeat (1) step();
    press(2); repeat (3) step();
    press(3); repeat (20) step();
    check("bounce_busy", busy1, 1'b0);
    check("bounce_led", led1, 8'h00);
    check("bounce_runs", runs, 0);

    // Clean run, pattern 5555_5555; Done lags the press by 6 debounce cycles plus the run.
    SW = 2'b11; p = cyc; press(6); wait_done(p, t1, t3);
    check("pass_lat_l1", t1, 136);
    check("pass_lat_l3", t3, 138);
    check("pass_led", led1, 8'h40);
    check("pass_fail", fail1, 1'b0);
    check("din_addr63", din63, 32'h5555_556A);
    check("one_run", runs, 1);

    // Fault on read of 0x2A.
    flip_on = 1'b1; p = cyc; press(6); wait_done(p, t1, t3);
    check("fail_lat_l1", t1, 115);
    check("fail_lat_l3", t3, 117);
    check("fail_flag", fail1, 1'b1);
    check("fail_err_addr", err1, 6'h2A);
    check("fail_led", led1, 8'hEA);
    repeat (5) step();
    check("fail_addr_held_l1", bus1.Ram_addr, 6'h2B);
    check("fail_addr_held_l3", bus3.Ram_addr, 6'h2D);
    flip_on = 1'b0;

    // Second press and SW change during FILL are ignored.
    SW = 2'b11; p = cyc; press(6);
    repeat (14) step();
    Start = 1'b1; repeat (4) step();
    SW = 2'b01;   repeat (4) step();
    Start = 1'b0;
    wait_done(p, t1, t3);
    check("ignored_lat_l1", t1, 136);
    check("ignored_runs", runs, 3);
    check("ignored_din63", din63, 32'h5555_556A);

    // Rerun after PASS picks up SW=01.
    p = cyc; press(6); wait_done(p, t1, t3);
    check("sw01_din_addr0", din0, 32'hFFFF_FFFF);
    check("sw01_lat_l1", t1, 136);

    // Reset during FILL.
    p = cyc; press(6);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (bus1.Ram_we && bus1.Ram_addr == 6'd20) found = 1;
    end
    check("reach_addr20", found, 1'b1);
    Rst = 1'b1;
    step();
    check("rst_we_l1", bus1.Ram_we, 1'b0);
    check("rst_led_l1", led1, 8'h00);
    check("rst_busy_l1", busy1, 1'b0);
    check("rst_we_l3", bus3.Ram_we, 1'b0);
    Rst = 1'b0;
    repeat (10) step();
    p = cyc; press(6); wait_done(p, t1, t3);
    check("restart_lat_l1", t1, 136);
    check("restart_lat_l3", t3, 138);
    check("restart_led_l3", led3, 8'h40);
    check("restart_fail_l3", fail3, 1'b0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
